// File: rtl/cpu_pkg.sv
// Shared types and widths for the fetch front end.
// State encoding, field widths and immediate sign-extension helper.
package cpu_pkg;

    localparam int WORD_W  = 32;
    localparam int IMM_W   = 16;
    localparam int JADDR_W = 26;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        HALT  = 2'd2,
        FAULT = 2'd3
    } state_t;

    function automatic logic [WORD_W-1:0] sext_imm(
        input logic [IMM_W-1:0] imm
    );
        return {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: halt > jump_reg > jump > branch > sequential.
// Ports: pc_plus1 and redirect inputs in; next_pc and halt_sel out.
module next_pc_sel
    import cpu_pkg::*;
(
    input  logic [WORD_W-1:0]  pc,
    input  logic [WORD_W-1:0]  pc_plus1,
    input  logic               halt,
    input  logic               jump_reg,
    input  logic [WORD_W-1:0]  rs_value,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jump_address,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   immediate,
    output logic [WORD_W-1:0]  next_pc,
    output logic               halt_sel
);

    logic [WORD_W-1:0] jmp_tgt;
    logic [WORD_W-1:0] br_tgt;

    // Jump keeps the upper region bits of the sequential address.
    assign jmp_tgt = {pc_plus1[WORD_W-1:JADDR_W], jump_address};
    assign br_tgt  = pc_plus1 + sext_imm(immediate);

    always_comb begin
        next_pc  = pc_plus1;
        halt_sel = 1'b0;
        priority case (1'b1)
            halt: begin
                next_pc  = pc;
                halt_sel = 1'b1;
            end
            jump_reg:     next_pc = rs_value;
            jump:         next_pc = jmp_tgt;
            branch_taken: next_pc = br_tgt;
            default:      next_pc = pc_plus1;
        endcase
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register, fetch FSM and fetched-instruction counter.
// Ports: redirect/stall/halt in; pc, pc_plus1, status, fetch_count out.
module pc_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'd0,
    parameter int          IMEM_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [IMM_W-1:0]   immediate,
    input  logic               jump,
    input  logic [JADDR_W-1:0] jump_address,
    input  logic               jump_reg,
    input  logic [WORD_W-1:0]  rs_value,
    input  logic               halt,
    output logic [WORD_W-1:0]  pc,
    output logic [WORD_W-1:0]  pc_plus1,
    output logic               fetch_valid,
    output logic               halted,
    output logic               fault,
    output logic [WORD_W-1:0]  fetch_count
);

    localparam logic [WORD_W-1:0] DEPTH = WORD_W'(IMEM_DEPTH);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] next_pc;
    logic              halt_sel;

    assign pc_plus1 = pc_q + 32'd1;

    next_pc_sel u_sel (
        .pc           (pc_q),
        .pc_plus1     (pc_plus1),
        .halt         (halt),
        .jump_reg     (jump_reg),
        .rs_value     (rs_value),
        .jump         (jump),
        .jump_address (jump_address),
        .branch_taken (branch_taken),
        .immediate    (immediate),
        .next_pc      (next_pc),
        .halt_sel     (halt_sel)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                if (!stall) begin
                    cnt_d = cnt_q + 32'd1;
                    if (halt_sel) begin
                        state_d = HALT;
                    end else begin
                        // Out-of-range target is kept in pc for debug.
                        pc_d = next_pc;
                        if (next_pc >= DEPTH)
                            state_d = FAULT;
                    end
                end
            end
            HALT:  state_d = HALT;
            FAULT: state_d = FAULT;
            default: state_d = BOOT;
        endcase
    end

    assign pc          = pc_q;
    assign fetch_count = cnt_q;
    assign fetch_valid = (state_q == RUN);
    assign halted      = (state_q == HALT);
    assign fault       = (state_q == FAULT);

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Program-counter and fetch-control stage directly upstream of the instruction memory. It holds the word-indexed PC that addresses the 32-entry instruction memory, selects the next PC from sequential, branch, jump and jump-register sources, and applies stall, halt and address-fault control. It also counts fetched instructions for debug and performance readout.

## Interface
- RESET_PC, 32'd0, PC value loaded on reset; word index, not byte address
- IMEM_DEPTH, 32, number of instruction words; any PC ≥ IMEM_DEPTH is a fault
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  freeze PC, state and counter this cycle
- branch_taken  in  1  conditional branch resolved taken
- immediate  in  16  branch offset in words, signed
- jump  in  1  J/JAL-type redirect
- jump_address  in  26  jump target field
- jump_reg  in  1  JR-type redirect
- rs_value  in  32  jump-register target, word index
- halt  in  1  stop fetching; sticky until reset
- pc  out  32  current fetch address to instruction memory
- pc_plus1  out  32  pc + 1, for link and branch base
- fetch_valid  out  1  the word at pc is a real instruction this cycle
- halted  out  1  FSM is in HALT
- fault  out  1  FSM is in FAULT
- fetch_count  out  32  instructions fetched since reset

## Operation
- FSM states: BOOT, RUN, HALT, FAULT.
- Reset (async, rst_n=0):
  - state=BOOT, pc=RESET_PC, fetch_count=0.
  - fetch_valid=0, halted=0, fault=0.
- BOOT: one cycle with fetch_valid=0, then unconditionally → RUN. The stall input is ignored in BOOT.
- RUN, stall=1: pc, state and fetch_count hold; fetch_valid=1 (same instruction presented again).
- RUN, stall=0:
  - fetch_count increments, wrapping modulo 2^32.
  - next_pc is chosen by priority: halt > jump_reg > jump > branch_taken > sequential.
- next_pc sources:
  - halt: pc holds; state → HALT.
  - jump_reg: rs_value.
  - jump: {pc_plus1[31:26], jump_address}.
  - branch_taken: pc_plus1 + sign_extend(immediate), 32-bit, wraps modulo 2^32.
  - sequential: pc_plus1.
- Fault check: if a non-halt next_pc ≥ IMEM_DEPTH, state → FAULT and pc is loaded with the offending value for debug.
- HALT and FAULT are absorbing until reset.
  - pc and fetch_count hold; fetch_valid=0.
  - halted=1 in HALT; fault=1 in FAULT.
  - All inputs are ignored.
- pc_plus1 is combinational pc+1 in all states.

## Timing
- Redirect inputs are sampled at the rising edge. The new pc is visible after that edge, so the target instruction appears the following cycle (1-cycle redirect latency).
- The instruction memory read is combinational. The pc-to-instruction path is in the same cycle and is external to this block.
- fetch_valid, halted and fault are registered state decodes: no combinational input-to-output path. Only pc_plus1 is combinational from pc.
- Simultaneous stall and redirect: stall wins and the redirect is discarded. The producer must hold the redirect until stall deasserts.
- Simultaneous halt and any redirect: halt wins.
- Simultaneous halt and stall: stall wins; halt is taken on the first unstalled cycle if still asserted.
- Reset asserted mid-operation: all registers return to reset values immediately (asynchronous). Exit to BOOT occurs on the first clk edge after rst_n rises.

## Structure
- Shared package (cpu_pkg):
  - state encoding enum: BOOT=2'd0, RUN=2'd1, HALT=2'd2, FAULT=2'd3
  - WORD_W=32, IMM_W=16, JADDR_W=26
- A natural sub-module is next_pc_sel, a purely combinational priority mux plus target arithmetic. The FSM, PC register and counter stay in pc_fetch_ctrl.

## Test plan
- Reset then 5 unstalled cycles → pc sequence 0,0,1,2,3,4; fetch_valid 0,1,1,1,1,1; fetch_count=4.
- At pc=6, branch_taken with immediate=16'hFFFC → next pc=3. Then immediate=16'h0005 at pc=3 → pc=9.
- At pc=4, assert jump, jump_reg (rs_value=20) and branch_taken together → pc=20 (jump_reg priority). Next, jump with jump_address=26'd7 → pc=7.
- Stall for 3 cycles at pc=5 while branch_taken=1 → pc stays 5 and fetch_count holds. After release with the branch still asserted, pc takes the branch target.
- Branch target 32 with IMEM_DEPTH=32 → fault=1, pc=32, fetch_valid=0. pc stays 32 for 10 cycles regardless of inputs.
- halt at pc=8 → halted=1 and pc stays 8. Pulse rst_n low mid-cycle → pc=0 immediately, then BOOT, then RUN.
